// File: rtl/wb_stream_master.sv
// wb_stream_master: Wishbone classic single-cycle master driven by a command stream.
//
// Each command accepted on the cmd_* valid/ready stream runs exactly one Wishbone
// cycle. The result (read data, or an error on timeout) comes back on the rsp_*
// valid/ready stream, one response per command and in order. All outputs are
// registered.
//
// Ports:
//   clk, rst                       clock; asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_we, cmd_adr, cmd_dat       command: write enable, address, write data
//   rsp_valid/rsp_ready            response handshake
//   rsp_dat, rsp_err               response: read data (0 for writes/errors), timeout flag
//   adr_o, dat_o, dat_i, we_o      Wishbone address, write data, read data, write enable
//   stb_o, cyc_o, ack_i            Wishbone strobe, cycle, acknowledge
//
// Parameters:
//   TIMEOUT     cycles to wait for ack_i before giving up (0 = wait forever)
//   GAP_CYCLES  idle cycles after each response handshake before the next command (0..15)

module wb_stream_master #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] adr_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  output logic        we_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i
);

  localparam int unsigned TcntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Count value seen on the edge at which the counter reaches TIMEOUT.
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);
  localparam logic [3:0]       GapLast  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp, StGap} state_e;

  state_e state_q, state_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      adr_q, adr_d;
  logic [15:0]      dat_q, dat_d;
  logic             we_q, we_d;
  // stb and cyc always move together for single-cycle transfers.
  logic             bus_q, bus_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [3:0]       gap_q, gap_d;

  logic accept, bus_ack, bus_timeout, rsp_hs, gap_done;

  // Only the state-qualified events are used, so ack_i outside BUS and
  // rsp_ready without rsp_valid have no effect.
  assign accept      = (state_q == StIdle) && cmd_ready_q && cmd_valid;
  assign bus_ack     = (state_q == StBus) && ack_i;
  // Ack in the same cycle as the timeout wins.
  assign bus_timeout = (state_q == StBus) && !ack_i && (TIMEOUT != 0) && (tcnt_q == TcntLast);
  assign rsp_hs      = (state_q == StResp) && rsp_valid_q && rsp_ready;
  assign gap_done    = (state_q == StGap) && (gap_q == GapLast);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBus;
      StBus:  if (bus_ack || bus_timeout) state_d = StResp;
      StResp: if (rsp_hs) state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
      StGap:  if (gap_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    bus_d       = bus_q;
    tcnt_d      = tcnt_q;
    gap_d       = gap_q;
    cmd_ready_d = (state_d == StIdle);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          adr_d  = cmd_adr;
          dat_d  = cmd_dat;
          we_d   = cmd_we;
          bus_d  = 1'b1;
          tcnt_d = '0;
        end
      end
      StBus: begin
        if (bus_ack) begin
          bus_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = we_q ? 16'h0000 : dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (bus_timeout) begin
          bus_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = 16'h0000;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end
      StResp: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          gap_d       = '0;
        end
      end
      StGap: begin
        gap_d = gap_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      bus_q       <= 1'b0;
      tcnt_q      <= '0;
      gap_q       <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      bus_q       <= bus_d;
      tcnt_q      <= tcnt_d;
      gap_q       <= gap_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign we_o      = we_q;
  assign stb_o     = bus_q;
  assign cyc_o     = bus_q;

endmodule

// File: tb/tb_wb_stream_master.sv
// Testbench for wb_stream_master (TIMEOUT = 64, GAP_CYCLES = 1). A small Wishbone
// slave with a registered ack answers bus cycles; expected responses are queued
// when commands are issued and compared as they are handshaken.

module tb_wb_stream_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [15:0] cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_dat;
  logic [31:0] adr_o;
  logic [15:0] dat_o, dat_i;
  logic        we_o, stb_o, cyc_o, ack_i;

  wb_stream_master #(
    .TIMEOUT   (64),
    .GAP_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .we_o     (we_o),
    .stb_o    (stb_o),
    .cyc_o    (cyc_o),
    .ack_i    (ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model
  logic        slave_auto = 1'b1;
  logic        ack_man = 1'b0;
  logic        use_mem = 1'b0;
  logic [15:0] slave_rdata = 16'h0000;
  logic        ack_reg = 1'b0;
  int          ack_count = 0;
  logic [15:0] mem [16];

  always @(posedge clk) begin
    if (slave_auto && cyc_o && stb_o && !ack_reg) begin
      ack_reg   <= 1'b1;
      ack_count <= ack_count + 1;
      if (we_o) mem[adr_o[5:2]] <= dat_o;
    end else begin
      ack_reg <= 1'b0;
    end
  end

  assign ack_i = ack_reg | ack_man;
  assign dat_i = use_mem ? mem[adr_o[5:2]] : slave_rdata;

  // Scoreboard
  typedef struct packed {
    logic [15:0] dat;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   push_count = 0;
  int   rsp_count  = 0;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_t e;
      rsp_count++;
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_dat", 32'(rsp_dat), 32'(e.dat));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Minimum stb_o low run between two strobes while enabled
  logic mon_en = 1'b0;
  logic stb_prev = 1'b0;
  logic seen_pulse = 1'b0;
  int   low_run = 0;
  int   gap_min = 1000;

  always @(negedge clk) begin
    if (!mon_en) begin
      seen_pulse <= 1'b0;
      low_run    <= 0;
    end else if (stb_o) begin
      if (!stb_prev && seen_pulse && low_run < gap_min) gap_min <= low_run;
      seen_pulse <= 1'b1;
      low_run    <= 0;
    end else begin
      low_run <= low_run + 1;
    end
    stb_prev <= stb_o;
  end

  // Issue one command; returns one time unit after the accepting edge.
  task automatic send(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                      input logic [15:0] exp_dat, input logic exp_err, input logic push);
    int   n = 0;
    rsp_t e;
    if (push) begin
      e.dat = exp_dat;
      e.err = exp_err;
      exp_q.push_back(e);
      push_count++;
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    while (n < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int stb_cnt;
    int cyc_cnt;
    int acks0;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b1;

    // Reset values
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cyc", 32'(cyc_o), 32'd0);
    check("rst_stb", 32'(stb_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_adr", adr_o, 32'd0);
    check("rst_dat_o", 32'(dat_o), 32'd0);
    check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write with a registered-ack slave: 2-cycle strobe, response 2 edges after accept
    acks0 = ack_count;
    send(1'b1, 32'h0000_2000, 16'h0040, 16'h0000, 1'b0, 1'b1);
    check("wr_stb", 32'(stb_o), 32'd1);
    check("wr_cyc", 32'(cyc_o), 32'd1);
    check("wr_we", 32'(we_o), 32'd1);
    check("wr_adr", adr_o, 32'h0000_2000);
    check("wr_dat_o", 32'(dat_o), 32'h0040);
    check("wr_cmd_ready_low", 32'(cmd_ready), 32'd0);
    stb_cnt = 1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lat++;
      if (stb_o) stb_cnt++;
      if (rsp_valid) break;
    end
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_stb_cycles", 32'(stb_cnt), 32'd2);
    check("wr_rsp_dat_now", 32'(rsp_dat), 32'd0);
    wait_drain();
    check("wr_one_ack", 32'(ack_count - acks0), 32'd1);

    // Read of the same address
    slave_rdata = 16'h0008;
    send(1'b0, 32'h0000_2000, 16'h0000, 16'h0008, 1'b0, 1'b1);
    check("rd_we_low", 32'(we_o), 32'd0);
    wait_drain();

    // Back-to-back commands, rsp_ready held high, data through slave memory
    use_mem = 1'b1;
    mon_en  = 1'b1;
    acks0   = ack_count;
    send(1'b1, 32'h0000_0010, 16'h1111, 16'h0000, 1'b0, 1'b1);
    send(1'b1, 32'h0000_0014, 16'h2222, 16'h0000, 1'b0, 1'b1);
    send(1'b0, 32'h0000_0010, 16'h0000, 16'h1111, 1'b0, 1'b1);
    send(1'b0, 32'h0000_0014, 16'h0000, 16'h2222, 1'b0, 1'b1);
    wait_drain();
    mon_en = 1'b0;
    check("b2b_acks", 32'(ack_count - acks0), 32'd4);
    check("b2b_stb_gap_ge2", 32'(gap_min >= 2), 32'd1);
    use_mem = 1'b0;

    // Response backpressure
    rsp_ready   = 1'b0;
    slave_rdata = 16'hBEEF;
    send(1'b0, 32'h0000_3000, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_dat", 32'(rsp_dat), 32'hBEEF);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_cyc", 32'(cyc_o), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_hs_valid_low", 32'(rsp_valid), 32'd0);
    check("bp_gap_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    check("bp_after_gap_ready", 32'(cmd_ready), 32'd1);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: slave never acks
    slave_auto = 1'b0;
    send(1'b0, 32'h0000_4000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    cyc_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!cyc_o) break;
      cyc_cnt++;
      step();
    end
    check("to_cyc_cycles", 32'(cyc_cnt), 32'd64);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_dat", 32'(rsp_dat), 32'd0);
    wait_drain();

    // Ack arriving on the 64th cycle wins over the timeout
    slave_rdata = 16'h1234;
    send(1'b0, 32'h0000_4004, 16'h0000, 16'h1234, 1'b0, 1'b1);
    repeat (63) step();
    check("to64_still_cyc", 32'(cyc_o), 32'd1);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("to64_cyc_low", 32'(cyc_o), 32'd0);
    check("to64_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to64_rsp_err", 32'(rsp_err), 32'd0);
    check("to64_rsp_dat", 32'(rsp_dat), 32'h1234);
    wait_drain();
    slave_auto = 1'b1;

    // Stray ack in IDLE
    step();
    check("stray_idle_ready", 32'(cmd_ready), 32'd1);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("stray_idle_no_rsp", 32'(rsp_valid), 32'd0);
    check("stray_idle_no_cyc", 32'(cyc_o), 32'd0);
    step();
    check("stray_idle_no_rsp2", 32'(rsp_valid), 32'd0);
    check("stray_idle_ready2", 32'(cmd_ready), 32'd1);

    // Stray ack in RESP
    rsp_ready   = 1'b0;
    slave_rdata = 16'h5A5A;
    send(1'b0, 32'h0000_6000, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
    wait_valid();
    slave_rdata = 16'h0F0F;
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("stray_resp_valid", 32'(rsp_valid), 32'd1);
    check("stray_resp_dat", 32'(rsp_dat), 32'h5A5A);
    check("stray_resp_cyc", 32'(cyc_o), 32'd0);
    rsp_ready = 1'b1;
    wait_drain();
    repeat (3) step();
    check("stray_resp_no_extra", 32'(rsp_valid), 32'd0);

    // Asynchronous reset in the middle of a bus cycle
    slave_rdata = 16'h7777;
    send(1'b0, 32'h0000_5000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("ar_stb_high", 32'(stb_o), 32'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("ar_cyc_low", 32'(cyc_o), 32'd0);
    check("ar_stb_low", 32'(stb_o), 32'd0);
    check("ar_rsp_valid_low", 32'(rsp_valid), 32'd0);
    check("ar_cmd_ready_low", 32'(cmd_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("ar_no_rsp", 32'(rsp_valid), 32'd0);
    slave_rdata = 16'h0C0C;
    send(1'b0, 32'h0000_5004, 16'h0000, 16'h0C0C, 1'b0, 1'b1);
    wait_drain();

    repeat (4) step();
    check("final_rsp_count", 32'(rsp_count), 32'(push_count));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
